hssi_tg_pkt_gen: RTL

HSSI_TG_PKT_GEN -- requirements
Module: hssi_tg_pkt_gen

---
 rtl/hssi_tg_pkg.sv | 24 ++
 rtl/hssi_tg_lfsr.sv | 21 ++
 rtl/hssi_tg_pkt_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hssi_tg_pkg.sv
// Shared constants, FSM state encoding and LFSR step function for the HSSI traffic generator.
package hssi_tg_pkg;
  localparam int TG_DATA_W     = 64;
  localparam int TG_KEEP_W     = TG_DATA_W / 8;
  localparam int TG_BEAT_SHIFT = $clog2(TG_KEEP_W);
  localparam int TG_BEAT_IDX_W = 16 - TG_BEAT_SHIFT;

  localparam logic [15:0] MIN_RAND_LEN = 16'd64;
  localparam logic [15:0] MAX_RAND_LEN = 16'd1518;

  // Right-shifting Galois form, toggle mask for a maximal-length 32-bit sequence
  localparam logic [31:0] LFSR_POLY = 32'hA300_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } tg_state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction
endpackage

// File: rtl/hssi_tg_lfsr.sv
// 32-bit Galois LFSR; the 64-bit word pairs the current state with its successor.
module hssi_tg_lfsr
  import hssi_tg_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h5EED_1234
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  output logic [63:0] data
);
  logic [31:0] state;

  always_ff @(posedge clk) begin
    if (!rst_n || load) state <= SEED;
    else if (adv)       state <= lfsr_step(state);
  end

  assign data = {lfsr_step(state), state};
endmodule

// File: rtl/hssi_tg_pkt_gen.sv
// AXI-Stream packet generator: fixed/random lengths, incremental/LFSR payload, graceful stop.
module hssi_tg_pkt_gen
  import hssi_tg_pkg::*;
#(
  parameter int          DATA_W    = TG_DATA_W,
  parameter logic [31:0] LFSR_SEED = 32'h5EED_1234
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          cfg_num_pkt,
  input  logic                 cfg_pkt_len_type,
  input  logic                 cfg_data_pattern,
  input  logic [15:0]          cfg_pkt_len,
  input  logic                 start,
  input  logic                 stop,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          pkt_cnt,
  output logic                 tx_tvalid,
  input  logic                 tx_tready,
  output logic [DATA_W-1:0]    tx_tdata,
  output logic [TG_KEEP_W-1:0] tx_tkeep,
  output logic                 tx_tlast
);
  tg_state_e                state;
  logic [31:0]              num_pkt_q;
  logic                     len_type_q;
  logic                     pattern_q;
  logic [15:0]              pkt_len_q;
  logic [31:0]              pkt_cnt_q;
  logic                     done_q;
  logic                     stop_req_q;
  logic [TG_BEAT_IDX_W-1:0] beat_idx_q;
  logic [TG_BEAT_IDX_W-1:0] last_idx_q;
  logic [TG_KEEP_W-1:0]     keep_last_q;
  logic [63:0]              lfsr_data;
  logic [63:0]              pat_word;
  logic [15:0]              load_len;
  logic                     run_start;
  logic                     accept;
  logic                     last_beat;
  logic                     lfsr_adv;

  function automatic logic [15:0] sat_len(input logic [10:0] raw);
    logic [15:0] v;
    v = {5'd0, raw};
    if (v < MIN_RAND_LEN) return MIN_RAND_LEN;
    if (v > MAX_RAND_LEN) return MAX_RAND_LEN;
    return v;
  endfunction

  function automatic logic [TG_KEEP_W-1:0] tail_keep(input logic [TG_BEAT_SHIFT-1:0] rem);
    logic [TG_KEEP_W-1:0] m;
    for (int k = 0; k < TG_KEEP_W; k++) m[k] = (rem == '0) || (k < int'(rem));
    return m;
  endfunction

  assign run_start = start && (state == ST_IDLE || state == ST_DONE);
  assign accept    = (state == ST_SEND) && tx_tready;
  assign last_beat = (beat_idx_q == last_idx_q);
  // The LFSR low word is the current state, so its bottom bits feed the random length
  assign load_len  = len_type_q ? sat_len(lfsr_data[10:0])
                               : ((pkt_len_q == 16'd0) ? 16'd1 : pkt_len_q);
  assign lfsr_adv  = ((state == ST_LOAD) && len_type_q) || (accept && pattern_q);

  assign busy      = (state == ST_LOAD) || (state == ST_SEND);
  assign done      = done_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign tx_tvalid = (state == ST_SEND);
  assign tx_tlast  = tx_tvalid && last_beat;

  hssi_tg_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (run_start),
    .adv   (lfsr_adv),
    .data  (lfsr_data)
  );

  always_comb begin
    pat_word = lfsr_data;
    if (!pattern_q)
      for (int k = 0; k < TG_KEEP_W; k++) pat_word[8*k +: 8] = {beat_idx_q[4:0], 3'(k)};
    tx_tkeep = '0;
    tx_tdata = '0;
    if (tx_tvalid) begin
      tx_tkeep = last_beat ? keep_last_q : '1;
      for (int k = 0; k < TG_KEEP_W; k++)
        if (tx_tkeep[k]) tx_tdata[8*k +: 8] = pat_word[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pkt_cnt_q  <= '0;
      done_q     <= 1'b0;
      stop_req_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (state == ST_DONE) done_q <= 1'b1;
          if (start) begin
            pkt_cnt_q  <= '0;
            done_q     <= 1'b0;
            stop_req_q <= 1'b0;
            state      <= (cfg_num_pkt == 32'd0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: state <= stop ? ST_DONE : ST_SEND;
        ST_SEND: begin
          // A stop during a packet is remembered and honoured at its tlast
          if (stop) stop_req_q <= 1'b1;
          if (accept && last_beat) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if ((pkt_cnt_q + 32'd1 == num_pkt_q) || stop || stop_req_q) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (run_start) begin
      num_pkt_q  <= cfg_num_pkt;
      len_type_q <= cfg_pkt_len_type;
      pattern_q  <= cfg_data_pattern;
      pkt_len_q  <= cfg_pkt_len;
    end
    if (state == ST_LOAD) begin
      beat_idx_q  <= '0;
      last_idx_q  <= TG_BEAT_IDX_W'((load_len - 16'd1) >> TG_BEAT_SHIFT);
      keep_last_q <= tail_keep(load_len[TG_BEAT_SHIFT-1:0]);
    end else if (accept && !last_beat) begin
      beat_idx_q <= beat_idx_q + TG_BEAT_IDX_W'(1);
    end
  end
endmodule
